// File: rtl/mux_pipe_skid_pkg.sv
// -----------------------------------------------------------------------------
// Package: mux_pipe_skid_pkg
// Purpose: Shared definitions for the mux_pipe_skid operand-select stage.
//   - State encodings of the two-entry skid buffer. Each state's value equals
//     the number of held beats, so the state register can drive the
//     occupancy output directly.
//   - clog2(): ceiling log2, used to derive the select width from the number
//     of sources.
// Ports: none (package).
// -----------------------------------------------------------------------------
package mux_pipe_skid_pkg;

  // Skid buffer states. The encoding equals the number of held beats.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Ceiling log2 for elaboration-time width derivation. A value of 1 or
  // less returns 0. Callers only use it with n >= 2.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage : mux_pipe_skid_pkg

// File: rtl/mux_pipe_skid_mux_n.sv
// -----------------------------------------------------------------------------
// Module: mux_n
// Purpose: Purely combinational N-way selector. It returns source 'sel' of a
//   packed source bus. A select value of NUM_IN or more has no matching
//   source, so in that case the output falls back to source 0.
// Ports:
//   in_data  in   NUM_IN*W  packed sources; source i is in_data[i*W +: W]
//   sel      in   SEL_W     source index
//   out_data out  W         selected source
// -----------------------------------------------------------------------------
module mux_n
  import mux_pipe_skid_pkg::*;
#(
  parameter int W      = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic [NUM_IN*W-1:0] in_data,
  input  logic [SEL_W-1:0]    sel,
  output logic [W-1:0]        out_data
);

  // NOTE: every signal written in always_comb gets a default on entry. A
  // path that leaves it unassigned would otherwise infer a latch. Here the
  // default is source 0, which also serves as the out-of-range fallback.
  always_comb begin
    out_data = in_data[0 +: W];
    for (int i = 1; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        out_data = in_data[i*W +: W];
      end
    end
  end

endmodule : mux_n

// File: rtl/mux_pipe_skid.sv
// -----------------------------------------------------------------------------
// Module: mux_pipe_skid
// Purpose: Parametrised N-way operand selector with a registered valid/ready
//   output stage. The selected source and its select value form one beat.
//   Accepted beats are held in a two-entry skid buffer (main + skid register)
//   that decouples producer and consumer at full throughput. in_ready is
//   registered, and no combinational path runs from in_* to out_*.
// Ports:
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   in_data    in   NUM_IN*W  packed sources; source i is in_data[i*W +: W]
//   in_sel     in   SEL_W     source index, sampled on accept
//   in_valid   in   1         producer offers a beat
//   in_ready   out  1         registered; block can accept a beat
//   flush      in   1         synchronous discard of all held beats
//   out_data   out  W         head beat data
//   out_src    out  SEL_W     select value that produced out_data
//   out_valid  out  1         head beat present
//   out_ready  in   1         consumer takes the head beat
//   occupancy  out  2         number of held beats, 0..2
// -----------------------------------------------------------------------------
module mux_pipe_skid
  import mux_pipe_skid_pkg::*;
#(
  parameter int W      = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = clog2(NUM_IN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IN*W-1:0] in_data,
  input  logic [SEL_W-1:0]    in_sel,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_src,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [1:0]          occupancy
);

  // ---------------------------------------------------------------------------
  // Operand select
  // ---------------------------------------------------------------------------
  logic [W-1:0] sel_data;

  mux_n #(
    .W      (W),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux_n (
    .in_data  (in_data),
    .sel      (in_sel),
    .out_data (sel_data)
  );

  // ---------------------------------------------------------------------------
  // State and storage
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q,     state_d;
  logic [W-1:0]     main_data_q, main_data_d;
  logic [SEL_W-1:0] main_src_q,  main_src_d;
  logic [W-1:0]     skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_src_q,  skid_src_d;
  logic             in_ready_q,  in_ready_d;

  logic accept;
  logic pop;

  // Both handshakes are seen by the same edge. in_ready_q is already 0 in
  // FULL, so an accept can never overflow the buffer.
  assign accept = in_valid & in_ready_q;
  assign pop    = (state_q != ST_EMPTY) & out_ready;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_src_d  = main_src_q;
    skid_data_d = skid_data_q;
    skid_src_d  = skid_src_q;

    if (flush) begin
      // Flush wins over accept and pop. Any beat offered in this cycle is
      // dropped. The data registers keep stale contents, and out_valid=0
      // hides them.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d     = ST_ONE;
            main_data_d = sel_data;
            main_src_d  = in_sel;
          end
        end
        ST_ONE: begin
          if (accept && !pop) begin
            // The head beat is stalled, so the new beat parks behind it.
            state_d     = ST_FULL;
            skid_data_d = sel_data;
            skid_src_d  = in_sel;
          end else if (accept && pop) begin
            // Streaming: the new beat replaces the departing head.
            main_data_d = sel_data;
            main_src_d  = in_sel;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // No accept is possible here. A pop promotes the parked beat to
          // the head, which keeps FIFO order.
          if (pop) begin
            state_d     = ST_ONE;
            main_data_d = skid_data_q;
            main_src_d  = skid_src_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end

    // in_ready is taken from the next state, so the register is correct in
    // the cycle after any transition. That includes the cycle right after a
    // pop from FULL.
    in_ready_d = (state_d != ST_FULL);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: the data registers get a reset as well as the control state.
  // These are only a few flops, not a memory array, and the output data must
  // read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      main_data_q <= '0;
      main_src_q  <= '0;
      skid_data_q <= '0;
      skid_src_q  <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment. Every
      // register then updates from values sampled before the edge.
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_src_q  <= main_src_d;
      skid_data_q <= skid_data_d;
      skid_src_q  <= skid_src_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = in_ready_q;
  assign out_data  = main_data_q;
  assign out_src   = main_src_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign occupancy = state_q;

endmodule : mux_pipe_skid

// File: tb/tb_mux_pipe_skid.sv
// -----------------------------------------------------------------------------
// Testbench: tb_mux_pipe_skid
// The main DUT uses W=32 and NUM_IN=4. A second instance uses W=8 and
// NUM_IN=3 to cover the out-of-range select. A queue model of the held beats
// predicts the main DUT's outputs on every falling edge. Directed steps pin
// literal values.
// -----------------------------------------------------------------------------
module tb_mux_pipe_skid;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int W3 = 8;
  localparam int N3 = 3;

  logic          clk;
  logic          rst_n;

  // Main DUT signals
  logic [N*W-1:0] in_data;
  logic [1:0]     in_sel;
  logic           in_valid;
  logic           in_ready;
  logic           flush;
  logic [W-1:0]   out_data;
  logic [1:0]     out_src;
  logic           out_valid;
  logic           out_ready;
  logic [1:0]     occupancy;

  // Three-source DUT signals
  logic [N3*W3-1:0] in_data3;
  logic [1:0]       in_sel3;
  logic             in_valid3;
  logic             in_ready3;
  logic             flush3;
  logic [W3-1:0]    out_data3;
  logic [1:0]       out_src3;
  logic             out_valid3;
  logic             out_ready3;
  logic [1:0]       occupancy3;

  int checks   = 0;
  int failures = 0;

  mux_pipe_skid #(.W(W), .NUM_IN(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  mux_pipe_skid #(.W(W3), .NUM_IN(N3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_sel    (in_sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .flush     (flush3),
    .out_data  (out_data3),
    .out_src   (out_src3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .occupancy (occupancy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: an ordered list of held beats, at most two.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [1:0]   src;
    logic [W-1:0] data;
  } beat_t;

  beat_t mq[$];

  always @(posedge clk or negedge rst_n) begin
    bit    acc;
    bit    pp;
    beat_t b;
    if (!rst_n || flush) begin
      mq.delete();
    end else begin
      acc    = in_valid && (mq.size() < 2);
      pp     = (mq.size() > 0) && out_ready;
      b.src  = in_sel;
      b.data = (int'(in_sel) < N) ? in_data[int'(in_sel)*W +: W] : in_data[W-1:0];
      if (pp)  void'(mq.pop_front());
      if (acc) mq.push_back(b);
    end
  end

  always @(negedge clk) begin
    check("m_valid", 64'(out_valid), 64'(mq.size() != 0));
    check("m_occ", 64'(occupancy), 64'(mq.size()));
    check("m_ready", 64'(in_ready), 64'(mq.size() < 2));
    if (mq.size() != 0) begin
      check("m_data", 64'(out_data), 64'(mq[0].data));
      check("m_src", 64'(out_src), 64'(mq[0].src));
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Source i holds 0x11*(i+1).
    in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
    in_data3  = {8'hC3, 8'hB2, 8'hA1};
    rst_n     = 1'b0;
    flush     = 1'b0;
    flush3    = 1'b0;
    in_valid  = 1'b1;   // offers during reset must be ignored
    in_sel    = 2'd1;
    out_ready = 1'b0;
    in_valid3 = 1'b1;
    in_sel3   = 2'd0;
    out_ready3 = 1'b0;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_src", 64'(out_src), 64'd0);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_occ3", 64'(occupancy3), 64'd0);
    in_valid  = 1'b0;
    in_valid3 = 1'b0;
    rst_n     = 1'b1;

    // Select source 2
    @(negedge clk);
    in_sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("sel_data", 64'(out_data), 64'h33);
    check("sel_src", 64'(out_src), 64'd2);
    check("sel_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("sel_drain", 64'(out_valid), 64'd0);

    // Backpressure: A=src0, B=src3
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd0;
    @(negedge clk);
    in_sel = 2'd3;
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_occ", 64'(occupancy), 64'd2);
    check("bp_ready", 64'(in_ready), 64'd0);
    check("bp_headA", 64'(out_data), 64'h11);
    @(negedge clk);
    check("bp_holdA", 64'(out_data), 64'h11);
    check("bp_holdAsrc", 64'(out_src), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_headB", 64'(out_data), 64'h44);
    check("bp_srcB", 64'(out_src), 64'd3);
    check("bp_ready_after", 64'(in_ready), 64'd1);
    check("bp_occ1", 64'(occupancy), 64'd1);
    @(negedge clk);
    check("bp_empty", 64'(occupancy), 64'd0);

    // Streaming, one beat per cycle
    in_valid = 1'b1; in_sel = 2'd0;
    for (int i = 0; i < 100; i++) begin
      in_data[W-1:0] = 32'(32'h1000 + i);
      @(negedge clk);
      check("st_data", 64'(out_data), 64'(32'h1000 + i));
      check("st_occ", 64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    in_data[W-1:0] = 32'h11;
    @(negedge clk);
    check("st_drain", 64'(out_valid), 64'd0);

    // Flush from FULL with a new offer in the flush cycle
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1;
    @(negedge clk);
    in_sel = 2'd2;
    @(negedge clk);
    check("fl_full", 64'(occupancy), 64'd2);
    in_sel = 2'd3; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_occ", 64'(occupancy), 64'd0);
    check("fl_valid", 64'(out_valid), 64'd0);
    check("fl_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    check("fl_nobeat", 64'(out_valid), 64'd0);

    // Flush from ONE, where the offer would otherwise be accepted
    in_valid = 1'b1; in_sel = 2'd1;
    @(negedge clk);
    check("fl1_one", 64'(occupancy), 64'd1);
    in_sel = 2'd3; flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_occ", 64'(occupancy), 64'd0);
    @(negedge clk);
    check("fl1_nobeat", 64'(out_valid), 64'd0);

    // Three-source instance: select 3 falls back to source 0
    in_valid3 = 1'b1; in_sel3 = 2'd3; out_ready3 = 1'b1;
    @(negedge clk);
    in_sel3 = 2'd2;
    check("oor_data", 64'(out_data3), 64'hA1);
    check("oor_src", 64'(out_src3), 64'd3);
    @(negedge clk);
    in_valid3 = 1'b0;
    check("n3_data", 64'(out_data3), 64'hC3);
    check("n3_src", 64'(out_src3), 64'd2);
    @(negedge clk);
    check("n3_drain", 64'(out_valid3), 64'd0);

    // Async reset while FULL
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd2;
    @(negedge clk);
    in_sel = 2'd3;
    @(negedge clk);
    in_valid = 1'b0;
    check("ar_full", 64'(occupancy), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid), 64'd0);
    check("ar_data", 64'(out_data), 64'd0);
    check("ar_src", 64'(out_src), 64'd0);
    check("ar_occ", 64'(occupancy), 64'd0);
    check("ar_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar_after", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mux_pipe_skid
